// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one framebuffer RAM port between the 8051 bridge (0) and the fill/blit engine (1).
// Round-robin grant with bounded burst lock, out-of-range rejection and 1-cycle read completion.
`default_nettype none

module mem_port_arbiter #(
  parameter int WIDTH     = 16,
  parameter int AWIDTH    = 13,
  parameter int MEMSIZE   = 4800,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic              i_lock0,
  input  logic [AWIDTH-1:0] i_addr0,
  input  logic [WIDTH-1:0]  i_wdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic              i_lock1,
  input  logic [AWIDTH-1:0] i_addr1,
  input  logic [WIDTH-1:0]  i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_mem_ce,
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]  o_mem_wdata,
  input  logic [WIDTH-1:0]  i_mem_rdata
);

  localparam int              CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);
  localparam logic [AWIDTH:0] MEM_LIMIT = (AWIDTH + 1)'(MEMSIZE);

  logic              last;
  logic              locked;
  logic [CW-1:0]     burst_cnt;

  logic              override;
  logic              sel;
  logic              any_req;
  logic              gnt0;
  logic              gnt1;
  logic              in_range;
  logic              we_g;
  logic              lock_g;
  logic [AWIDTH-1:0] addr_g;
  logic [WIDTH-1:0]  wdata_g;
  logic              cpl0;
  logic              cpl1;

  // On a tie the previous grantee keeps the port only while its burst lock is within budget.
  always_comb begin
    override = locked && (burst_cnt < BURST_MAX);
    if (i_req0 && i_req1) begin
      sel = override ? last : ~last;
    end else begin
      sel = i_req1;
    end
  end

  assign any_req  = i_req0 | i_req1;
  assign gnt0     = any_req & ~sel;
  assign gnt1     = any_req & sel;
  assign addr_g   = sel ? i_addr1  : i_addr0;
  assign wdata_g  = sel ? i_wdata1 : i_wdata0;
  assign we_g     = sel ? i_we1    : i_we0;
  assign lock_g   = sel ? i_lock1  : i_lock0;
  assign in_range = ({1'b0, addr_g} < MEM_LIMIT);

  assign o_ack0      = gnt0;
  assign o_ack1      = gnt1;
  assign o_mem_ce    = any_req & in_range;
  assign o_mem_we    = o_mem_ce & we_g;
  assign o_mem_addr  = any_req ? addr_g  : '0;
  assign o_mem_wdata = any_req ? wdata_g : '0;

  // Reads and every rejected access produce a completion; in-range writes do not.
  assign cpl0 = gnt0 & (~i_we0 | ~in_range);
  assign cpl1 = gnt1 & (~i_we1 | ~in_range);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last      <= 1'b1;
      locked    <= 1'b0;
      burst_cnt <= '0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_err0    <= 1'b0;
      o_err1    <= 1'b0;
    end else begin
      if (any_req) begin
        last   <= sel;
        locked <= lock_g;
        if (sel != last) begin
          burst_cnt <= CW'(1);
        end else if (burst_cnt < BURST_MAX) begin
          burst_cnt <= burst_cnt + CW'(1);
        end
      end else begin
        locked    <= 1'b0;
        burst_cnt <= '0;
      end
      o_rvalid0 <= cpl0;
      o_rvalid1 <= cpl1;
      o_err0    <= gnt0 & ~in_range;
      o_err1    <= gnt1 & ~in_range;
    end
  end

  // Only one completion can be outstanding, so the RAM output needs no steering.
  assign o_rdata = ((o_rvalid0 && !o_err0) || (o_rvalid1 && !o_err1)) ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized + directed scoreboard bench for mem_port_arbiter.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MAXB = 4;
  localparam int MSZ  = 4800;

  typedef struct {
    bit          r;
    bit          we;
    bit          lock;
    logic [12:0] addr;
    logic [15:0] wd;
  } req_t;

  typedef struct {
    int          cyc;
    bit          a0;
    bit          a1;
    bit          ce;
    bit          we;
    bit          gnt;
    logic [12:0] addr;
    logic [15:0] wdata;
  } cyc_t;

  typedef struct {
    int          due;
    bit          err;
    logic [15:0] data;
  } cmp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [12:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata;
  logic        mem_ce, mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic [15:0] ram    [0:8191];
  logic [15:0] shadow [0:8191];

  cyc_t exp_cyc[$];
  cmp_t rq0[$];
  cmp_t rq1[$];
  int   hist_g[$];
  bit   hist_l[$];
  int   last_id = 1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(16), .AWIDTH(13), .MEMSIZE(MSZ), .MAX_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_we0(we0), .i_lock0(lock0), .i_addr0(addr0), .i_wdata0(wdata0),
    .i_req1(req1), .i_we1(we1), .i_lock1(lock1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_err0(err0), .o_err1(err1), .o_rdata(rdata),
    .o_mem_ce(mem_ce), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Registered-output RAM seen by the DUT.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Grant prediction from the recent grant history: a tie goes to the other requester
  // unless the current holder asked for lock and its run is still shorter than MAXB.
  function automatic int predict(input bit r0, input bit r1);
    int n, g, run;
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    n = hist_g.size();
    if (n > 0 && hist_g[n-1] != -1 && hist_l[n-1]) begin
      g = hist_g[n-1];
      run = 0;
      for (int i = n - 1; i >= 0; i--) begin
        if (hist_g[i] != g) break;
        run++;
      end
      if (run < MAXB) return g;
    end
    return 1 - last_id;
  endfunction

  function automatic req_t mk(input bit r, input bit w, input bit l,
                              input logic [12:0] a, input logic [15:0] d);
    req_t q;
    q.r = r; q.we = w; q.lock = l; q.addr = a; q.wd = d;
    return q;
  endfunction

  task automatic drive(input req_t q0, input req_t q1, output bit g0, output bit g1);
    cyc_t e;
    cmp_t c;
    req_t qg;
    int   g;
    bit   inr;
    @(negedge clk);
    rst_n = 1'b1;
    req0 = q0.r; we0 = q0.we; lock0 = q0.lock; addr0 = q0.addr; wdata0 = q0.wd;
    req1 = q1.r; we1 = q1.we; lock1 = q1.lock; addr1 = q1.addr; wdata1 = q1.wd;
    cyc++;
    g = predict(q0.r, q1.r);
    e = '{cyc: cyc, a0: (g == 0), a1: (g == 1), ce: 0, we: 0, gnt: (g >= 0), addr: '0, wdata: '0};
    if (g >= 0) begin
      qg = (g == 1) ? q1 : q0;
      inr = (int'(qg.addr) < MSZ);
      e.ce = inr;
      e.we = inr && qg.we;
      e.addr = qg.addr;
      e.wdata = qg.wd;
      c.due = cyc + 1;
      c.err = !inr;
      c.data = '0;
      if (inr && qg.we) shadow[qg.addr] = qg.wd;
      else begin
        if (inr) c.data = shadow[qg.addr];
        if (g == 0) rq0.push_back(c);
        else        rq1.push_back(c);
      end
      hist_g.push_back(g);
      hist_l.push_back(qg.lock);
      last_id = g;
    end else begin
      hist_g.push_back(-1);
      hist_l.push_back(1'b0);
    end
    if (hist_g.size() > 16) begin
      void'(hist_g.pop_front());
      void'(hist_l.pop_front());
    end
    exp_cyc.push_back(e);
    g0 = (g == 0);
    g1 = (g == 1);
  endtask

  task automatic do_reset();
    cyc_t e;
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    cyc++;
    rq0.delete();
    rq1.delete();
    hist_g.delete();
    hist_l.delete();
    last_id = 1;
    e = '{cyc: cyc, a0: 0, a1: 0, ce: 0, we: 0, gnt: 0, addr: '0, wdata: '0};
    exp_cyc.push_back(e);
  endtask

  // Monitor: compares every presented cycle and every completion against the queues.
  initial begin
    cyc_t e;
    cmp_t c0, c1;
    bit v0, v1;
    logic [15:0] xr;
    forever begin
      @(negedge clk);
      #2;
      if (exp_cyc.size() > 0) begin
        e = exp_cyc.pop_front();
        check("ack0", 32'(ack0), 32'(e.a0));
        check("ack1", 32'(ack1), 32'(e.a1));
        check("mem_ce", 32'(mem_ce), 32'(e.ce));
        check("mem_we", 32'(mem_we), 32'(e.we));
        if (e.ce || !e.gnt) begin
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
        v0 = (rq0.size() > 0) && (rq0[0].due == e.cyc);
        v1 = (rq1.size() > 0) && (rq1[0].due == e.cyc);
        c0 = '{due: 0, err: 0, data: '0};
        c1 = '{due: 0, err: 0, data: '0};
        if (v0) c0 = rq0.pop_front();
        if (v1) c1 = rq1.pop_front();
        check("rvalid0", 32'(rvalid0), 32'(v0));
        check("rvalid1", 32'(rvalid1), 32'(v1));
        check("err0", 32'(err0), 32'(v0 && c0.err));
        check("err1", 32'(err1), 32'(v1 && c1.err));
        xr = (v0 && !c0.err) ? c0.data : ((v1 && !c1.err) ? c1.data : 16'h0);
        check("rdata", 32'(rdata), 32'(xr));
      end
    end
  end

  function automatic logic [12:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2)      return 13'($urandom_range(MSZ, 8191));
    else if (r < 6) return 13'($urandom_range(0, 7));
    else            return 13'($urandom_range(0, MSZ - 1));
  endfunction

  initial begin
    req_t idle, p0, p1;
    bit g0, g1;
    logic [15:0] v;
    for (int i = 0; i < 8192; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      shadow[i] = v;
    end
    idle = mk(0, 0, 0, '0, '0);
    do_reset();
    // Plain round-robin reads.
    for (int i = 0; i < 6; i++) drive(mk(1, 0, 0, 13'd10, '0), mk(1, 0, 0, 13'd20, '0), g0, g1);
    // Locked burst against a waiting requester.
    do_reset();
    for (int i = 0; i < 10; i++) drive(mk(1, 0, 1, 13'd10, '0), mk(1, 0, 0, 13'd20, '0), g0, g1);
    // Read after write.
    drive(mk(1, 1, 0, 13'd5, 16'hBEEF), idle, g0, g1);
    drive(mk(1, 0, 0, 13'd5, '0), idle, g0, g1);
    drive(idle, idle, g0, g1);
    // Out-of-range boundary.
    drive(idle, mk(1, 0, 0, 13'd4800, '0), g0, g1);
    drive(idle, mk(1, 0, 0, 13'd4799, '0), g0, g1);
    drive(idle, idle, g0, g1);
    // Reset mid-burst with a read completion pending.
    do_reset();
    for (int i = 0; i < 2; i++) drive(mk(1, 0, 1, 13'd11, '0), mk(1, 0, 0, 13'd21, '0), g0, g1);
    do_reset();
    for (int i = 0; i < 4; i++) drive(mk(1, 0, 0, 13'd12, '0), mk(1, 0, 0, 13'd22, '0), g0, g1);
    // Lone locked requester never stalls.
    for (int i = 0; i < 6; i++) drive(idle, mk(1, 0, 1, 13'd30, '0), g0, g1);
    drive(idle, idle, g0, g1);
    // Random traffic, requests held until acked.
    p0 = idle;
    p1 = idle;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        p0 = idle;
        p1 = idle;
      end
      if (!p0.r && $urandom_range(0, 99) < 60)
        p0 = mk(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      if (!p1.r && $urandom_range(0, 99) < 60)
        p1 = mk(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      drive(p0, p1, g0, g1);
      if (g0) p0 = idle;
      if (g1) p1 = idle;
    end
    for (int i = 0; i < 3; i++) drive(idle, idle, g0, g1);
    @(negedge clk);
    #4;
    check("drain", 32'(rq0.size() + rq1.size() + exp_cyc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
